// File: rtl/spin_pkg.sv
// Shared constants for the wheel-position sequencer: position range, FSM
// encoding, speed codes and the wrap-around step helper.
package spin_pkg;

   localparam int             POS_W   = 3;
   localparam int             NUM_POS = 6;
   localparam logic [POS_W-1:0] POS_MAX = 3'd5;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam logic [1:0] SPD_SLOW  = 2'd0;
   localparam logic [1:0] SPD_MED   = 2'd1;
   localparam logic [1:0] SPD_QUICK = 2'd2;
   localparam logic [1:0] SPD_FAST  = 2'd3;

   // Out-of-range positions collapse to 0 so an upset never sticks.
   function automatic logic [POS_W-1:0] pos_wrap(input logic [POS_W-1:0] pos,
                                                 input logic             dec,
                                                 input logic [POS_W-1:0] last);
      logic [POS_W-1:0] nxt;
      if (pos > last)
         nxt = '0;
      else if (dec)
         nxt = (pos == '0) ? last : pos - 1'b1;
      else
         nxt = (pos == last) ? '0 : pos + 1'b1;
      return nxt;
   endfunction

endpackage

// File: rtl/spin_ctrl_if.sv
// Board-side control and position bus of the wheel sequencer.
interface spin_ctrl_if;
   import spin_pkg::*;

   logic             en_i;
   logic             dir_i;
   logic [1:0]       speed_i;
   logic             step_i;
   logic [POS_W-1:0] pos_o;
   logic             tick_o;
   logic             run_o;

   modport master (
      output en_i, dir_i, speed_i, step_i,
      input  pos_o, tick_o, run_o
   );

   modport slave (
      input  en_i, dir_i, speed_i, step_i,
      output pos_o, tick_o, run_o
   );

endinterface

// File: rtl/spin_prescaler.sv
// Rate prescaler: counts clocks and flags a terminal cycle once the count
// reaches (BASE_DIV >> speed_i) - 1.
module spin_prescaler #(
   parameter int DIV_W    = 20,
   parameter int BASE_DIV = 1000000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       clr_i,
   input  logic [1:0] speed_i,
   output logic       tick_o
);

   localparam logic [DIV_W-1:0] BASE = DIV_W'(BASE_DIV);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] limit;
   logic             at_limit;

   assign limit = (BASE >> speed_i) - DIV_W'(1);

   // >= rather than == so a speed change that lowers the limit below the
   // current count fires on the next edge instead of waiting for a rollover.
   assign at_limit = (cnt >= limit);
   assign tick_o   = !clr_i && at_limit;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         cnt <= '0;
      else if (clr_i || at_limit)
         cnt <= '0;
      else
         cnt <= cnt + DIV_W'(1);
   end

endmodule

// File: rtl/spin_ctrl.sv
// Wheel-position sequencer: steps pos_o through 0..NUM_POS-1 at a prescaled
// rate or by manual step. Ping-pong mode is built when SPIN_BOUNCE_EN is defined.
//
// state | meaning
// IDLE  | stopped; prescaler held clear, step_i rising edges advance once
// RUN   | spinning; each prescaler terminal cycle advances, steps ignored
module spin_ctrl #(
   parameter int DIV_W    = 20,
   parameter int BASE_DIV = 1000000,
   parameter int NUM_POS  = 6
) (
   input  logic        clk_i,
   input  logic        rst_i,
   spin_ctrl_if.slave  bus
);
   import spin_pkg::*;

   localparam logic [POS_W-1:0] LAST = POS_W'(NUM_POS - 1);

   logic [0:0]       state;
   logic             step_q;
   logic             pre_tick;
   logic             step_edge;
   logic             advance;
   logic [POS_W-1:0] pos_q;
   logic [POS_W-1:0] pos_nxt;
   logic             tick_q;

   spin_prescaler #(
      .DIV_W    (DIV_W),
      .BASE_DIV (BASE_DIV)
   ) u_prescaler (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (state == IDLE),
      .speed_i (bus.speed_i),
      .tick_o  (pre_tick)
   );

   assign step_edge = bus.step_i && !step_q;

   // A step coinciding with en_i rising is dropped in favour of entering RUN.
   assign advance = (state == RUN) ? pre_tick : (step_edge && !bus.en_i);

`ifdef SPIN_BOUNCE_EN
   logic dir_q;
   logic adv_dir;
   logic dir_nxt;

   assign adv_dir = (state == RUN) ? dir_q : bus.dir_i;

   always_comb begin
      pos_nxt = pos_wrap(pos_q, adv_dir, LAST);
      dir_nxt = adv_dir;
      if (pos_q <= LAST) begin
         if (!adv_dir && pos_q == LAST) begin
            pos_nxt = LAST - 1'b1;
            dir_nxt = 1'b1;
         end else if (adv_dir && pos_q == '0) begin
            pos_nxt = POS_W'(1);
            dir_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         dir_q <= 1'b0;
      else if (state == IDLE && bus.en_i)
         dir_q <= bus.dir_i;
      else if (advance)
         dir_q <= dir_nxt;
   end
`else
   always_comb begin
      pos_nxt = pos_wrap(pos_q, bus.dir_i, LAST);
   end
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state  <= IDLE;
         step_q <= 1'b0;
         pos_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         state  <= bus.en_i ? RUN : IDLE;
         step_q <= bus.step_i;
         tick_q <= advance;
         if (advance)
            pos_q <= pos_nxt;
      end
   end

   assign bus.pos_o  = pos_q;
   assign bus.tick_o = tick_q;
   assign bus.run_o  = state[0];

endmodule

// File: doc/spin_ctrl.md
Name: spin_ctrl

Overview:
- Sequencer that generates the wheel position consumed by the segment driver.
- Steps a 3-bit position through 0..5 at a programmable rate, in a selectable direction, with a single-step mode while stopped.
- Sits between the board inputs (enable/direction/speed/step) and the position-to-segment decode.

Parameters:
- DIV_W, 20, prescaler counter width.
- BASE_DIV, 1000000, prescaler period in clocks at speed 0. Must satisfy 8 ≤ BASE_DIV < 2^DIV_W.
- NUM_POS, 6, number of wheel positions. The legal position range is 0..NUM_POS-1.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; asynchronous, active-high.
- en_i  in  1  run enable; 1 = continuous spinning.
- dir_i  in  1  direction; 0 = increment (A→B→…→F), 1 = decrement.
- speed_i  in  2  rate select; tick period = BASE_DIV >> speed_i clocks.
- step_i  in  1  manual step request. Level input; the block detects the rising edge internally.
- pos_o  out  3  current wheel position, 0..NUM_POS-1.
- tick_o  out  1  one-cycle pulse in the same cycle pos_o takes a new value.
- run_o  out  1  1 while the FSM is in RUN.

Behaviour:
- Reset (async assert, released synchronously to clk_i):
  - pos_o=0, tick_o=0, run_o=0.
  - Prescaler count=0, step edge register=0, FSM=IDLE, internal direction=0.
- All outputs are registered.
- FSM states: IDLE, RUN.
  - IDLE→RUN when en_i=1. RUN→IDLE when en_i=0.
  - The transition takes effect at the next clock edge. run_o reflects the new state in the same cycle.
- Prescaler:
  - Clears on entry to RUN and while in IDLE. Otherwise increments each clock.
  - Limit L = (BASE_DIV >> speed_i) - 1.
  - When count ≥ L: count←0 and an advance occurs on that edge.
  - Because the compare is ≥, a speed_i change mid-count never stalls. If the count is already past the new limit, the advance happens on the next edge.
  - First advance after entering RUN occurs L+1 clocks after the entry edge.
- Step edge detection:
  - step_q registers step_i every cycle.
  - A rising edge (step_i=1, step_q=0) in IDLE produces exactly one advance on that edge.
  - Steps are ignored in RUN.
  - Holding step_i high produces only one advance.
- Advance:
  - Increment: pos 5→0 wraps, otherwise pos+1.
  - Decrement: pos 0→5 wraps, otherwise pos-1.
  - tick_o=1 for exactly that cycle, else 0.
- Direction:
  - dir_i is sampled at each advance.
  - A change between advances alters only the next advance, never the current position.
- Simultaneous events:
  - en_i rising in the same cycle as a step edge: FSM enters RUN and the step is dropped.
  - en_i falling on a prescaler-terminal cycle: the advance still occurs and the FSM enters IDLE.
- pos_o never leaves 0..NUM_POS-1. Any illegal value (e.g. after an SEU) is forced to 0 on the next advance.
- Reset mid-run: immediate return to the reset values, with no tick_o glitch.

Optional Feature:
- Macro SPIN_BOUNCE_EN.
- Defined (ping-pong mode):
  - Reaching 5 while incrementing or 0 while decrementing flips the internal direction register instead of wrapping. The sequence is 0,1,2,3,4,5,4,3,…
  - The internal direction loads from dir_i on IDLE→RUN and on each step in IDLE.
  - In RUN, dir_i is ignored.
- Undefined: wrap-around as specified above. The internal direction register is absent and dir_i is used directly.

Decomposition:
- Package spin_pkg holds:
  - POS_W=3, NUM_POS=6, POS_MAX=3'd5.
  - State encoding IDLE=1'b0, RUN=1'b1.
  - Speed codes SPD_SLOW=2'd0 … SPD_FAST=2'd3.
- Sub-module spin_prescaler(clk_i, rst_i, clr_i, speed_i, tick_o):
  - Owns the counter and the ≥-limit compare.
  - Parameterised by DIV_W and BASE_DIV.
- FSM, edge detect and position logic remain in spin_ctrl.

Test Plan (BASE_DIV=16 for simulation):
- Reset asserted mid-run with pos_o=3 → pos_o=0, tick_o=0 and run_o=0 asynchronously, before the next clock edge.
- en_i=1, dir_i=0, speed_i=0 → first tick_o 16 clocks after the RUN entry edge. Sequence 1,2,3,4,5,0,1 at 16-clock spacing, with tick_o one cycle wide each time.
- speed_i 0→2 when the prescaler count is 10 → advance on the next edge (10 ≥ 3), then period 4.
- en_i=0, pos_o=0, dir_i=1, step_i held high 5 cycles → exactly one tick_o, pos_o=5. A second pulse gives pos_o=4.
- en_i 0→1 in the same cycle as a step rising edge → no immediate advance. run_o=1 and the first tick comes after 16 clocks.
- SPIN_BOUNCE_EN defined, en_i=1, dir_i=0 → sequence 1,2,3,4,5,4,3,2,1,0,1. Toggling dir_i during RUN has no effect.
